// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: a sync-marked beat stream of U,V,W,X symbols is
// collected into shadow registers and published to the lane outputs as whole frames.
module tdm_demux4 #(
  parameter int WIDTH = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] M,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [1:0]       s,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0] u_q, v_q, w_q, x_q;
  logic             valid_q, err_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= HUNT;
      cnt_q   <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      u_q     <= '0;
      v_q     <= '0;
      w_q     <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (en) begin
        unique case (state_q)
          HUNT: begin
            if (sync) begin
              sh0_q   <= M;
              cnt_q   <= 2'd1;
              state_q <= LOCKED;
            end
          end
          LOCKED: begin
            // A marker always restarts the frame; mid-frame it also flags an error.
            if (sync) begin
              err_q <= (cnt_q != 2'd0);
              sh0_q <= M;
              cnt_q <= 2'd1;
            end else if (cnt_q == 2'd0) begin
              err_q   <= 1'b1;
              state_q <= HUNT;
            end else if (cnt_q == 2'd3) begin
              u_q     <= sh0_q;
              v_q     <= sh1_q;
              w_q     <= sh2_q;
              x_q     <= M;
              valid_q <= 1'b1;
              cnt_q   <= 2'd0;
            end else begin
              if (cnt_q == 2'd1) sh1_q <= M;
              else               sh2_q <= M;
              cnt_q <= cnt_q + 2'd1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign U      = u_q;
  assign V      = v_q;
  assign W      = w_q;
  assign X      = x_q;
  assign s      = cnt_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized and directed bench for tdm_demux4 against a frame-queue reference model.
module tb_tdm_demux4;
  localparam int WIDTH = 2;

  logic             Clock  = 1'b0;
  logic             Resetn = 1'b1;
  logic             en     = 1'b0;
  logic             sync   = 1'b0;
  logic [WIDTH-1:0] M      = '0;
  logic [WIDTH-1:0] U, V, W, X;
  logic [1:0]       s;
  logic             valid, locked, err;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Resetn(Resetn), .M(M), .en(en), .sync(sync),
    .U(U), .V(V), .W(W), .X(X), .s(s),
    .valid(valid), .locked(locked), .err(err)
  );

  always #5 Clock = ~Clock;

  int vecs = 0;
  int errs = 0;

  // Reference model: the symbols of the frame in progress are kept in a queue.
  logic [WIDTH-1:0] frame_q[$];
  bit               m_locked;
  logic [WIDTH-1:0] mU, mV, mW, mX;
  bit               m_valid, m_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_locked = 0;
    mU = '0; mV = '0; mW = '0; mX = '0;
    m_valid = 0; m_err = 0;
  endtask

  task automatic model_beat(input logic e, input logic sy, input logic [WIDTH-1:0] m);
    m_valid = 0;
    m_err   = 0;
    if (!e) return;
    if (!m_locked) begin
      if (sy) begin
        frame_q  = '{m};
        m_locked = 1;
      end
    end else if (sy) begin
      m_err   = (frame_q.size() != 0);
      frame_q = '{m};
    end else if (frame_q.size() == 0) begin
      m_err    = 1;
      m_locked = 0;
    end else begin
      frame_q.push_back(m);
      if (frame_q.size() == 4) begin
        mU = frame_q[0]; mV = frame_q[1]; mW = frame_q[2]; mX = frame_q[3];
        m_valid = 1;
        frame_q.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("U", U, mU);
    chk("V", V, mV);
    chk("W", W, mW);
    chk("X", X, mX);
    chk("s", s, frame_q.size());
    chk("valid", valid, m_valid);
    chk("err", err, m_err);
    chk("locked", locked, m_locked);
    chk("valid_err_excl", valid & err, 0);
  endtask

  task automatic beat(input logic e, input logic sy, input logic [WIDTH-1:0] m);
    en = e; sync = sy; M = m;
    @(posedge Clock);
    model_beat(e, sy, m);
    #1;
    check_all();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, WIDTH'($urandom));
  endtask

  task automatic do_reset();
    #1 Resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single frame after reset
    beat(1, 1, 1); beat(1, 0, 2); beat(1, 0, 3); beat(1, 0, 0);
    chk("f1_U", U, 1); chk("f1_V", V, 2); chk("f1_W", W, 3); chk("f1_X", X, 0);
    chk("f1_valid", valid, 1); chk("f1_locked", locked, 1); chk("f1_s", s, 0);

    // Back-to-back frames
    beat(1, 1, 1); chk("b2b_valid_off", valid, 0);
    beat(1, 0, 2); beat(1, 0, 3); beat(1, 0, 0);
    chk("b2b_v1", valid, 1);
    beat(1, 1, 3); beat(1, 0, 3); beat(1, 0, 2); beat(1, 0, 1);
    chk("b2b_v2", valid, 1);
    chk("b2b_U", U, 3); chk("b2b_V", V, 3); chk("b2b_W", W, 2); chk("b2b_X", X, 1);

    // Frame with en gaps
    beat(1, 1, 2); gap(2); beat(1, 0, 1); gap(2); beat(1, 0, 0); gap(2); beat(1, 0, 3);
    chk("gap_valid", valid, 1);
    chk("gap_U", U, 2); chk("gap_V", V, 1); chk("gap_W", W, 0); chk("gap_X", X, 3);
    gap(2);
    chk("gap_hold_U", U, 2);

    // Early marker at slot 2
    beat(1, 1, 0); beat(1, 0, 0);
    beat(1, 1, 1); chk("early_err", err, 1); chk("early_valid", valid, 0);
    beat(1, 0, 2); beat(1, 0, 3); beat(1, 0, 0);
    chk("early_fr_valid", valid, 1);
    chk("early_U", U, 1); chk("early_V", V, 2); chk("early_W", W, 3); chk("early_X", X, 0);

    // Missing marker at slot 0
    beat(1, 0, 3); chk("miss_err", err, 1); chk("miss_locked", locked, 0);
    chk("miss_hold_U", U, 1);
    beat(1, 0, 2); beat(1, 0, 1); beat(1, 0, 0); beat(1, 0, 3);
    chk("miss_still_hunt", locked, 0);
    beat(1, 1, 3); chk("miss_relock", locked, 1);
    beat(1, 0, 2); beat(1, 0, 1); beat(1, 0, 2);

    // Reset mid-frame
    beat(1, 1, 2); beat(1, 0, 2);
    do_reset();
    chk("rst_U", U, 0); chk("rst_X", X, 0); chk("rst_locked", locked, 0);
    beat(1, 0, 1); beat(1, 0, 1);
    chk("rst_no_valid", valid, 0); chk("rst_s", s, 0);

    // Randomized traffic, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else beat($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, WIDTH'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, default 2, lane/symbol width in bits.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 M  input  WIDTH  time-multiplexed symbol stream; one lane per beat, slot order U,V,W,X.
REQ-005 en  input  1  beat qualifier; M and sync are sampled only when en=1.
REQ-006 sync  input  1  frame marker; 1 on the slot-0 (U) beat.
REQ-007 U, V, W, X  output  WIDTH each  registered demultiplexed lanes, slots 0..3.
REQ-008 s  output  2  slot index expected on the next beat (current counter).
REQ-009 valid  output  1  one-cycle pulse: a complete frame has been loaded into U..X.
REQ-010 locked  output  1  1 when the FSM is in LOCKED.
REQ-011 err  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 The FSM SHALL have two states: HUNT and LOCKED; locked = (state==LOCKED).
REQ-013 The 2-bit slot counter s SHALL advance only on accepted beats and wrap 3->0.
REQ-014 Three WIDTH-bit shadow registers SHALL hold slots 0..2 of the frame in progress.
REQ-015 en=0: no state, counter, shadow or output change; valid=0, err=0.
REQ-016 HUNT, en=1, sync=0: beat discarded, remain HUNT, s stays 0, no err.
REQ-017 HUNT, en=1, sync=1: M->shadow[0], s<=1, next state LOCKED.
REQ-018 LOCKED, en=1, s in {1,2}, sync=0: M->shadow[s], s<=s+1.
REQ-019 LOCKED, en=1, s=3, sync=0: U<=shadow[0], V<=shadow[1], W<=shadow[2], X<=M, all at the same edge; valid=1 for that next cycle; s<=0.
REQ-020 Output latency: U..X and valid SHALL update at the clock edge that samples the slot-3 beat; they are visible one cycle after that beat is presented.
REQ-021 LOCKED, en=1, s=0, sync=1: normal frame start; M->shadow[0], s<=1.
REQ-022 LOCKED, en=1, s=0, sync=0 (missing marker): err pulse, beat discarded, s stays 0, next state HUNT.
REQ-023 LOCKED, en=1, s in {1,2,3}, sync=1 (early marker): err pulse, partial frame discarded (no U..X update, no valid), M->shadow[0], s<=1, remain LOCKED.
REQ-024 The early-marker rule SHALL take priority over the slot-3 completion rule.
REQ-025 U..X SHALL hold their last complete frame between valid pulses; partial frames never reach outputs.
REQ-026 valid and err SHALL never be 1 in the same cycle.
REQ-027 All outputs SHALL be driven from registers; there are no combinational input-to-output paths.

Reset
REQ-028 Resetn=0 SHALL asynchronously set state=HUNT, s=0, shadows=0, U=V=W=X=0, valid=0, err=0, locked=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL require a fresh sync beat before loading a frame.
REQ-030 The first accepted beat SHALL be on the first rising edge with Resetn=1 and en=1.

Verification
REQ-031 Reset, then en=1 on four consecutive beats M=1,2,3,0 with sync=1 on the first -> one cycle after the 4th beat U=1,V=2,W=3,X=0, valid=1 for exactly one cycle, locked=1, s=0.
REQ-032 Back-to-back frames (1,2,3,0 then 3,3,2,1) with no gaps -> two valid pulses 4 cycles apart; second yields U=3,V=3,W=2,X=1.
REQ-033 Frame 2,1,0,3 with en=0 for 2 cycles between each beat -> no change during gaps; single valid after 4th beat; U=2,V=1,W=0,X=3.
REQ-034 After a locked frame, sync=1 on slot 2 with M=1, then M=2,3,0 -> err pulse at the early marker, no valid for the aborted frame, then valid with U=1,V=2,W=3,X=0.
REQ-035 While locked, slot-0 beat with sync=0 -> err pulse, locked=0, outputs hold previous frame; subsequent non-sync beats ignored until sync=1.
REQ-036 Resetn pulsed low after 2 beats of a frame -> all outputs 0 immediately; the next 2 beats without sync produce no valid.
